// File: rtl/sprite_pkg.sv
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared types and constants for the sprite motion controller:
//                heading encoding, keypad / PS/2 code values and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

  // Heading encoding. Opposite headings differ only in bit 0.
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  // Matrix keypad scan codes
  localparam logic [4:0] c_key_left  = 5'h0C;
  localparam logic [4:0] c_key_right = 5'h0E;
  localparam logic [4:0] c_key_down  = 5'h09;
  localparam logic [4:0] c_key_up    = 5'h11;

  // PS/2 make codes (arrow keys)
  localparam logic [7:0] c_kbd_left  = 8'h6B;
  localparam logic [7:0] c_kbd_right = 8'h74;
  localparam logic [7:0] c_kbd_up    = 8'h75;
  localparam logic [7:0] c_kbd_down  = 8'h72;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PROBE_TURN = 2'd1,
    ST_PROBE_FWD  = 2'd2,
    ST_APPLY      = 2'd3
  } state_t;

  function automatic dir_t f_opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_dir_decoder.sv
// ============================================================================
//  Module      : key_dir_decoder
//  Description : Edge-detects the keypad and PS/2 ready levels, maps codes to
//                headings and merges both sources (PS/2 has priority).
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk          in   system clock
//    rst          in   synchronous active-high reset
//    i_key_code   in   [4:0] keypad scan code
//    i_key_ready  in   keypad code valid (level)
//    i_kbd_code   in   [7:0] PS/2 make code
//    i_kbd_ready  in   PS/2 code valid (level)
//    o_req_valid  out  one-cycle pulse: a new recognised direction request
//    o_req_dir    out  [1:0] requested heading (valid with o_req_valid)
// ============================================================================
`default_nettype none

module key_dir_decoder
  import sprite_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] i_key_code,
  input  logic       i_key_ready,
  input  logic [7:0] i_kbd_code,
  input  logic       i_kbd_ready,
  output logic       o_req_valid,
  output logic [1:0] o_req_dir
);

  logic r_key_ready_d;
  logic r_kbd_ready_d;
  logic w_key_edge;
  logic w_kbd_edge;
  logic w_key_hit;
  logic w_kbd_hit;
  dir_t w_key_dir;
  dir_t w_kbd_dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_ready_d <= 1'b0;
      r_kbd_ready_d <= 1'b0;
    end else begin
      r_key_ready_d <= i_key_ready;
      r_kbd_ready_d <= i_kbd_ready;
    end
  end

  assign w_key_edge = i_key_ready & ~r_key_ready_d;
  assign w_kbd_edge = i_kbd_ready & ~r_kbd_ready_d;

  always_comb begin
    w_key_hit = 1'b1;
    w_key_dir = DIR_UP;
    case (i_key_code)
      c_key_left:  w_key_dir = DIR_LEFT;
      c_key_right: w_key_dir = DIR_RIGHT;
      c_key_down:  w_key_dir = DIR_DOWN;
      c_key_up:    w_key_dir = DIR_UP;
      default:     w_key_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_kbd_hit = 1'b1;
    w_kbd_dir = DIR_UP;
    case (i_kbd_code)
      c_kbd_left:  w_kbd_dir = DIR_LEFT;
      c_kbd_right: w_kbd_dir = DIR_RIGHT;
      c_kbd_up:    w_kbd_dir = DIR_UP;
      c_kbd_down:  w_kbd_dir = DIR_DOWN;
      default:     w_kbd_hit = 1'b0;
    endcase
  end

  // A recognised PS/2 press overrides a simultaneous keypad press; an
  // unrecognised code on either source is simply not a request.
  always_comb begin
    o_req_valid = 1'b0;
    o_req_dir   = DIR_UP;
    if (w_kbd_edge && w_kbd_hit) begin
      o_req_valid = 1'b1;
      o_req_dir   = w_kbd_dir;
    end else if (w_key_edge && w_key_hit) begin
      o_req_valid = 1'b1;
      o_req_dir   = w_key_dir;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
// ============================================================================
//  Module      : sprite_motion_ctrl
//  Description : Single-sprite motion controller. Buffers a pending turn,
//                probes candidate moves against the maze on every step tick
//                and updates the position with tunnel wrap-around.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk, rst                 clock, synchronous active-high reset
//    i_en                     0 = ignore ticks / freeze position
//    i_key_code, i_key_ready  keypad code and level-valid
//    i_kbd_code, i_kbd_ready  PS/2 make code and level-valid
//    o_probe_req/x/y/dir      maze probe request (held until ack)
//    i_probe_ack, i_probe_free probe result
//    o_pos_x, o_pos_y         sprite position
//    o_dir                    current heading
//    o_moving                 last tick produced a move
//    o_turn_pending           buffered turn differs from heading
// ============================================================================
`default_nettype none

module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int         X_W          = 10,
  parameter int         Y_W          = 9,
  parameter int         X_INIT       = 320,
  parameter int         Y_INIT       = 146,
  parameter logic [1:0] DIR_INIT     = 2'b00,
  parameter int         STEP_DIV     = 131072,
  parameter int         STEP_PX      = 1,
  parameter int         X_MIN        = 0,
  parameter int         X_MAX        = 639,
  parameter int         Y_MIN        = 0,
  parameter int         Y_MAX        = 479,
  parameter int         TURN_HOLD    = 8,
  parameter int         REVERSE_FAST = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_en,
  input  logic [4:0]     i_key_code,
  input  logic           i_key_ready,
  input  logic [7:0]     i_kbd_code,
  input  logic           i_kbd_ready,
  output logic           o_probe_req,
  output logic [X_W-1:0] o_probe_x,
  output logic [Y_W-1:0] o_probe_y,
  output logic [1:0]     o_probe_dir,
  input  logic           i_probe_ack,
  input  logic           i_probe_free,
  output logic [X_W-1:0] o_pos_x,
  output logic [Y_W-1:0] o_pos_y,
  output logic [1:0]     o_dir,
  output logic           o_moving,
  output logic           o_turn_pending
);

  localparam int c_tick_w = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(STEP_DIV - 1);
  localparam int c_hold_w = (TURN_HOLD > 1) ? $clog2(TURN_HOLD) : 1;
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(TURN_HOLD - 1);

  // Wrap thresholds precomputed so the candidate logic compares before it
  // subtracts and never underflows the position width.
  localparam logic [X_W-1:0] c_x_min  = X_W'(X_MIN);
  localparam logic [X_W-1:0] c_x_max  = X_W'(X_MAX);
  localparam logic [X_W-1:0] c_x_lo   = X_W'(X_MIN + STEP_PX);
  localparam logic [X_W-1:0] c_x_hi   = X_W'(X_MAX - STEP_PX);
  localparam logic [X_W-1:0] c_x_step = X_W'(STEP_PX);
  localparam logic [Y_W-1:0] c_y_min  = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] c_y_max  = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] c_y_lo   = Y_W'(Y_MIN + STEP_PX);
  localparam logic [Y_W-1:0] c_y_hi   = Y_W'(Y_MAX - STEP_PX);
  localparam logic [Y_W-1:0] c_y_step = Y_W'(STEP_PX);

  function automatic logic [X_W-1:0] f_step_x(input logic [X_W-1:0] x, input dir_t d);
    logic [X_W-1:0] nx;
    nx = x;
    if (d == DIR_LEFT)  nx = (x < c_x_lo) ? c_x_max : x - c_x_step;
    if (d == DIR_RIGHT) nx = (x > c_x_hi) ? c_x_min : x + c_x_step;
    return nx;
  endfunction

  function automatic logic [Y_W-1:0] f_step_y(input logic [Y_W-1:0] y, input dir_t d);
    logic [Y_W-1:0] ny;
    ny = y;
    if (d == DIR_UP)   ny = (y < c_y_lo) ? c_y_max : y - c_y_step;
    if (d == DIR_DOWN) ny = (y > c_y_hi) ? c_y_min : y + c_y_step;
    return ny;
  endfunction

  logic [c_tick_w-1:0] r_tick_cnt;
  state_t              r_state;
  dir_t                r_dir;
  dir_t                r_pend_dir;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [X_W-1:0]      r_pos_x;
  logic [Y_W-1:0]      r_pos_y;
  logic                r_moving;
  logic                r_turn_pending;
  logic                r_probe_req;
  logic [X_W-1:0]      r_probe_x;
  logic [Y_W-1:0]      r_probe_y;
  dir_t                r_probe_dir;

  logic                w_tick;
  logic                w_req_valid;
  logic [1:0]          w_req_dir_raw;
  dir_t                w_req_dir;
  logic                w_rev_fast;
  dir_t                w_dir_eff;
  dir_t                w_pend_eff;
  logic                w_start_turn;
  dir_t                w_start_dir;
  logic                w_ack;

  key_dir_decoder u_key_dir_decoder (
    .clk         (clk),
    .rst         (rst),
    .i_key_code  (i_key_code),
    .i_key_ready (i_key_ready),
    .i_kbd_code  (i_kbd_code),
    .i_kbd_ready (i_kbd_ready),
    .o_req_valid (w_req_valid),
    .o_req_dir   (w_req_dir_raw)
  );

  assign w_req_dir = dir_t'(w_req_dir_raw);
  assign w_tick    = (r_tick_cnt == c_tick_last);
  assign w_ack     = i_probe_ack & r_probe_req;

  // Heading and pending turn as they will stand after this cycle's request,
  // so a tick coinciding with a request probes the up-to-date direction.
  always_comb begin
    w_rev_fast   = (REVERSE_FAST != 0) && (r_state == ST_IDLE) && w_req_valid
                   && (w_req_dir == f_opposite(r_dir));
    w_dir_eff    = w_rev_fast ? w_req_dir : r_dir;
    w_pend_eff   = w_req_valid ? w_req_dir : r_pend_dir;
    w_start_turn = (w_pend_eff != w_dir_eff);
    w_start_dir  = w_start_turn ? w_pend_eff : w_dir_eff;
  end

  always_ff @(posedge clk) begin
    if (rst) r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_dir          <= dir_t'(DIR_INIT);
      r_pend_dir     <= dir_t'(DIR_INIT);
      r_hold_cnt     <= '0;
      r_pos_x        <= X_W'(X_INIT);
      r_pos_y        <= Y_W'(Y_INIT);
      r_moving       <= 1'b0;
      r_turn_pending <= 1'b0;
      r_probe_req    <= 1'b0;
      r_probe_x      <= '0;
      r_probe_y      <= '0;
      r_probe_dir    <= dir_t'(DIR_INIT);
    end else begin
      r_turn_pending <= (r_pend_dir != r_dir);
      case (r_state)
        ST_IDLE: begin
          if (w_rev_fast) r_dir <= w_req_dir;
          if (w_tick && i_en) begin
            r_probe_req <= 1'b1;
            r_probe_x   <= f_step_x(r_pos_x, w_start_dir);
            r_probe_y   <= f_step_y(r_pos_y, w_start_dir);
            r_probe_dir <= w_start_dir;
            r_state     <= w_start_turn ? ST_PROBE_TURN : ST_PROBE_FWD;
          end
        end
        ST_PROBE_TURN: begin
          if (w_ack) begin
            r_probe_req <= 1'b0;
            if (i_probe_free) begin
              // Take the heading actually probed; a request arriving during
              // the handshake only updates the pending turn.
              r_dir   <= r_probe_dir;
              r_state <= ST_APPLY;
            end else begin
              if (TURN_HOLD != 0) begin
                if (r_hold_cnt == c_hold_last) begin
                  r_hold_cnt <= '0;
                  r_pend_dir <= r_dir;
                end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
                end
              end
              if (i_en) begin
                // Load the forward candidate now; the request is re-raised
                // one cycle later so req drops for a cycle after every ack.
                r_probe_x   <= f_step_x(r_pos_x, r_dir);
                r_probe_y   <= f_step_y(r_pos_y, r_dir);
                r_probe_dir <= r_dir;
                r_state     <= ST_PROBE_FWD;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
        end
        ST_PROBE_FWD: begin
          if (!r_probe_req) begin
            r_probe_req <= 1'b1;
          end else if (w_ack) begin
            r_probe_req <= 1'b0;
            if (i_probe_free) begin
              r_state <= ST_APPLY;
            end else begin
              r_moving <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
        end
        ST_APPLY: begin
          if (i_en) begin
            r_pos_x  <= r_probe_x;
            r_pos_y  <= r_probe_y;
            r_moving <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_req_valid) begin
        r_pend_dir <= w_req_dir;
        r_hold_cnt <= '0;
      end
    end
  end

  assign o_probe_req    = r_probe_req;
  assign o_probe_x      = r_probe_x;
  assign o_probe_y      = r_probe_y;
  assign o_probe_dir    = r_probe_dir;
  assign o_pos_x        = r_pos_x;
  assign o_pos_y        = r_pos_y;
  assign o_dir          = r_dir;
  assign o_moving       = r_moving;
  assign o_turn_pending = r_turn_pending;

endmodule

`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
// ============================================================================
//  Module      : tb_sprite_motion_ctrl
//  Description : Scoreboard bench for sprite_motion_ctrl. Stimulus pushes the
//                expected probes and moves; a negedge monitor answers probes
//                and compares against the queues.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_motion_ctrl;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] d;
    logic       free;
  } probe_e;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] d;
    int         per;
  } pos_e;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [4:0] key_code = '0;
  logic       key_ready = 1'b0;
  logic [7:0] kbd_code = '0;
  logic       kbd_ready = 1'b0;
  logic       probe_req;
  logic [9:0] probe_x;
  logic [8:0] probe_y;
  logic [1:0] probe_dir;
  logic       ack = 1'b0;
  logic       free = 1'b0;
  logic [9:0] pos_x;
  logic [8:0] pos_y;
  logic [1:0] dir;
  logic       moving;
  logic       turn_pending;

  int n_cmp = 0;
  int n_fail = 0;
  probe_e exp_probe[$];
  pos_e   exp_pos[$];
  bit     ack_en = 1'b1;

  always #5 clk = ~clk;

  sprite_motion_ctrl #(
    .STEP_DIV     (8),
    .TURN_HOLD    (2),
    .REVERSE_FAST (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_en           (en),
    .i_key_code     (key_code),
    .i_key_ready    (key_ready),
    .i_kbd_code     (kbd_code),
    .i_kbd_ready    (kbd_ready),
    .o_probe_req    (probe_req),
    .o_probe_x      (probe_x),
    .o_probe_y      (probe_y),
    .o_probe_dir    (probe_dir),
    .i_probe_ack    (ack),
    .i_probe_free   (free),
    .o_pos_x        (pos_x),
    .o_pos_y        (pos_y),
    .o_dir          (dir),
    .o_moving       (moving),
    .o_turn_pending (turn_pending)
  );

  // ---------------- monitor / probe responder ----------------
  int         cyc = 0;
  int         ack_cyc = 0;
  int         move_cyc = 0;
  logic       prev_req = 1'b0;
  logic [9:0] prev_x = '0;
  logic [8:0] prev_y = '0;

  always @(negedge clk) begin : mon
    probe_e pe;
    pos_e   qe;
    cyc++;
    if (rst) begin
      ack = 1'b0;
      prev_req = 1'b0;
      prev_x = pos_x;
      prev_y = pos_y;
    end else begin
      if (ack) begin
        ack = 1'b0;
      end else if (probe_req && !prev_req) begin
        n_cmp++;
        if (exp_probe.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_probe: got x=%0d y=%0d dir=%0d, required no probe",
                   probe_x, probe_y, probe_dir);
          ack = 1'b1;
          free = 1'b0;
          ack_cyc = cyc;
        end else begin
          pe = exp_probe.pop_front();
          if (probe_x !== pe.x || probe_y !== pe.y || probe_dir !== pe.d) begin
            n_fail++;
            $display("FAIL probe: got x=%0d y=%0d dir=%0d, required x=%0d y=%0d dir=%0d",
                     probe_x, probe_y, probe_dir, pe.x, pe.y, pe.d);
          end
          if (ack_en) begin
            ack = 1'b1;
            free = pe.free;
            ack_cyc = cyc;
          end
        end
      end
      prev_req = probe_req;

      if (pos_x !== prev_x || pos_y !== prev_y) begin
        n_cmp++;
        if (exp_pos.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_move: got pos=(%0d,%0d), required (%0d,%0d)",
                   pos_x, pos_y, prev_x, prev_y);
        end else begin
          qe = exp_pos.pop_front();
          if (pos_x !== qe.x || pos_y !== qe.y || dir !== qe.d || moving !== 1'b1
              || (cyc - ack_cyc) != 2) begin
            n_fail++;
            $display("FAIL move: got pos=(%0d,%0d) dir=%0d moving=%0d ack_lat=%0d, required pos=(%0d,%0d) dir=%0d moving=1 ack_lat=2",
                     pos_x, pos_y, dir, moving, cyc - ack_cyc, qe.x, qe.y, qe.d);
          end
          if (qe.per != 0) begin
            n_cmp++;
            if ((cyc - move_cyc) != qe.per) begin
              n_fail++;
              $display("FAIL step_period: got %0d clocks, required %0d", cyc - move_cyc, qe.per);
            end
          end
        end
        move_cyc = cyc;
        prev_x = pos_x;
        prev_y = pos_y;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic push_probe(input int x, input int y, input int d, input bit f);
    probe_e e;
    e.x = 10'(x); e.y = 9'(y); e.d = 2'(d); e.free = f;
    exp_probe.push_back(e);
  endtask

  task automatic push_pos(input int x, input int y, input int d, input int per);
    pos_e e;
    e.x = 10'(x); e.y = 9'(y); e.d = 2'(d); e.per = per;
    exp_pos.push_back(e);
  endtask

  // Run with en=1 until both queues are consumed, then freeze again.
  task automatic run_until_drained(input int budget);
    int k;
    k = 0;
    en = 1'b1;
    while ((exp_probe.size() != 0 || exp_pos.size() != 0) && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    en = 1'b0;
    if (exp_probe.size() != 0 || exp_pos.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d probes and %0d moves outstanding, required 0",
               exp_probe.size(), exp_pos.size());
      exp_probe.delete();
      exp_pos.delete();
    end
  endtask

  task automatic press_kbd(input logic [7:0] code);
    @(negedge clk);
    kbd_code = code;
    kbd_ready = 1'b1;
    repeat (3) @(negedge clk);
    kbd_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pos_x", 32'(pos_x), 320);
    chk("rst_pos_y", 32'(pos_y), 146);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_moving", 32'(moving), 0);
    chk("rst_probe_req", 32'(probe_req), 0);
    chk("rst_turn_pending", 32'(turn_pending), 0);
    rst = 1'b0;

    // Straight up, one pixel per 8-clock tick
    push_probe(320, 145, 0, 1'b1); push_pos(320, 145, 0, 0);
    push_probe(320, 144, 0, 1'b1); push_pos(320, 144, 0, 8);
    run_until_drained(100);
    repeat (3) @(negedge clk);

    // Simultaneous keypad-left and PS/2-right: right wins, turn is blocked twice
    @(negedge clk);
    key_code = 5'h0C; key_ready = 1'b1;
    kbd_code = 8'h74; kbd_ready = 1'b1;
    repeat (3) @(negedge clk);
    key_ready = 1'b0; kbd_ready = 1'b0;
    chk("sim_turn_pending", 32'(turn_pending), 1);
    chk("sim_dir_kept", 32'(dir), 0);
    push_probe(321, 144, 3, 1'b0); push_probe(320, 143, 0, 1'b1); push_pos(320, 143, 0, 0);
    push_probe(321, 143, 3, 1'b0); push_probe(320, 142, 0, 1'b1); push_pos(320, 142, 0, 8);
    run_until_drained(200);
    repeat (3) @(negedge clk);
    chk("hold_expired_turn_pending", 32'(turn_pending), 0);
    chk("hold_expired_dir", 32'(dir), 0);

    // PS/2 left turn accepted
    press_kbd(8'h6B);
    chk("left_turn_pending", 32'(turn_pending), 1);
    push_probe(319, 142, 2, 1'b1); push_pos(319, 142, 2, 0);
    run_until_drained(100);
    repeat (3) @(negedge clk);
    chk("left_dir", 32'(dir), 2);
    chk("left_turn_cleared", 32'(turn_pending), 0);

    // Walk left to x=0, then wrap to X_MAX
    for (int x = 318; x >= 0; x--) begin
      push_probe(x, 142, 2, 1'b1); push_pos(x, 142, 2, 0);
    end
    push_probe(639, 142, 2, 1'b1); push_pos(639, 142, 2, 0);
    run_until_drained(4000);
    repeat (3) @(negedge clk);
    chk("wrap_left_pos_x", 32'(pos_x), 639);

    // Reverse while idle: applied next cycle without a probe
    @(negedge clk);
    kbd_code = 8'h74; kbd_ready = 1'b1;
    @(negedge clk);
    chk("reverse_dir", 32'(dir), 3);
    chk("reverse_no_probe", 32'(probe_req), 0);
    repeat (2) @(negedge clk);
    kbd_ready = 1'b0;
    chk("reverse_turn_pending", 32'(turn_pending), 0);

    // Wrap right from X_MAX to X_MIN
    push_probe(0, 142, 3, 1'b1); push_pos(0, 142, 3, 0);
    run_until_drained(100);
    repeat (3) @(negedge clk);
    chk("wrap_right_pos_x", 32'(pos_x), 0);

    // Forward probe blocked
    push_probe(1, 142, 3, 1'b0);
    run_until_drained(100);
    repeat (3) @(negedge clk);
    chk("blocked_moving", 32'(moving), 0);
    chk("blocked_pos_x", 32'(pos_x), 0);
    chk("blocked_pos_y", 32'(pos_y), 142);

    // Reset in the middle of an unanswered probe
    ack_en = 1'b0;
    push_probe(1, 142, 3, 1'b0);
    run_until_drained(100);
    repeat (2) @(negedge clk);
    chk("midprobe_req_held", 32'(probe_req), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midprobe_req_drop", 32'(probe_req), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    chk("midrst_pos_x", 32'(pos_x), 320);
    chk("midrst_pos_y", 32'(pos_y), 146);
    chk("midrst_dir", 32'(dir), 0);
    chk("midrst_moving", 32'(moving), 0);
    chk("midrst_turn_pending", 32'(turn_pending), 0);
    repeat (12) @(negedge clk);
    chk("idle_no_probe", 32'(probe_req), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required summary before 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
